// File: rtl/mem_ctrl_pkg.sv
// Shared types and width helpers for the memory port controller.
package mem_ctrl_pkg;

  typedef enum logic {INIT, RUN} state_t;

  // Packed widths of the request and response records for the FIFOs.
  function automatic int req_w(input int aw, input int width, input int tag_w);
    return 1 + aw + width + tag_w;
  endfunction

  function automatic int rsp_w(input int width, input int tag_w);
    return width + tag_w;
  endfunction

endpackage

// File: rtl/mem_port_ctrl_if.sv
// Client request/response and memory port bundle for mem_port_ctrl.
interface mem_port_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int TAG_W = 4
);
  localparam int AW = $clog2(DEPTH);

  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_rdata;
  logic [TAG_W-1:0] rsp_tag;
  logic             mem_re;
  logic [AW-1:0]    mem_raddr;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_tag, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_tag,
    output mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_tag, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_tag,
    input  mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata
  );

endinterface

// File: rtl/mem_port_ctrl_fifo.sv
// Synchronous FIFO with first-word-fall-through head; push into a full FIFO
// is accepted when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pdata,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = store[rptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) store[wptr] <= pdata;
  end

endmodule

// File: rtl/mem_port_ctrl.sv
// In-order requester for a dual-ported memory: queues tagged requests, issues
// one per cycle, and returns read data through a response FIFO.
module mem_port_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               DEPTH      = 32,
  parameter int               TAG_W      = 4,
  parameter int               REQ_DEPTH  = 4,
  parameter int               RSP_DEPTH  = 4,
  parameter int               INIT_EN    = 0,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic               clock,
  input  logic               reset,
  mem_port_ctrl_if.slave     bus,
  output logic               busy
);
  localparam int            AW    = $clog2(DEPTH);
  localparam int            REQ_W = req_w(AW, WIDTH, TAG_W);
  localparam int            RSP_W = rsp_w(WIDTH, TAG_W);
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  typedef struct packed {
    logic             write;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] wdata;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0] rdata;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt;

  req_t req_in, req_head;
  rsp_t rsp_in, rsp_head;
  logic req_push, req_pop, req_full, req_empty;
  logic rsp_push, rsp_pop, rsp_full, rsp_empty;
  logic [$clog2(REQ_DEPTH):0] req_cnt;
  logic [$clog2(RSP_DEPTH):0] rsp_cnt;

  assign req_in   = '{write: bus.req_write, addr: bus.req_addr,
                      wdata: bus.req_wdata, tag: bus.req_tag};
  assign req_push = bus.req_valid && bus.req_ready;
  assign rsp_in   = '{rdata: bus.mem_rdata, tag: req_head.tag};
  assign rsp_pop  = bus.rsp_valid && bus.rsp_ready;

  sync_fifo #(.WIDTH(REQ_W), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .clock(clock), .reset(reset), .push(req_push), .pdata(req_in), .pop(req_pop),
    .full(req_full), .empty(req_empty), .count(req_cnt), .head(req_head)
  );

  sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clock(clock), .reset(reset), .push(rsp_push), .pdata(rsp_in), .pop(rsp_pop),
    .full(rsp_full), .empty(rsp_empty), .count(rsp_cnt), .head(rsp_head)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= (INIT_EN != 0) ? INIT : RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) cnt <= cnt + 1'b1;
    end
  end

  // Issue stage: the whole memory port is gated off during the reset cycle.
  always_comb begin
    state_nxt     = state;
    req_pop       = 1'b0;
    rsp_push      = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_waddr = '0;
    bus.mem_wdata = '0;
    bus.mem_re    = 1'b0;
    bus.mem_raddr = '0;
    if (!reset) begin
      case (state)
        INIT: begin
          bus.mem_we    = 1'b1;
          bus.mem_waddr = cnt;
          bus.mem_wdata = INIT_VALUE;
          if (cnt == LAST) state_nxt = RUN;
        end
        RUN: begin
          if (!req_empty) begin
            if (req_head.write) begin
              bus.mem_we    = 1'b1;
              bus.mem_waddr = req_head.addr;
              bus.mem_wdata = req_head.wdata;
              req_pop       = 1'b1;
            end else if (!rsp_full || rsp_pop) begin
              bus.mem_re    = 1'b1;
              bus.mem_raddr = req_head.addr;
              rsp_push      = 1'b1;
              req_pop       = 1'b1;
            end
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  assign bus.req_ready = (state == RUN) && !req_full;
  assign bus.rsp_valid = !rsp_empty;
  assign bus.rsp_rdata = rsp_empty ? '0 : rsp_head.rdata;
  assign bus.rsp_tag   = rsp_empty ? '0 : rsp_head.tag;
  assign busy          = (state == INIT) || (req_cnt != '0) || (rsp_cnt != '0);

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Self-checking bench for mem_port_ctrl with a behavioural memory and an
// in-order shadow-memory scoreboard for read responses.
module tb_mem_port_ctrl;
  localparam logic [31:0] IV = 32'hA5A5_A5A5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic busy;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  mem_port_ctrl_if #(.WIDTH(32), .DEPTH(32), .TAG_W(4)) bus ();

  mem_port_ctrl #(
    .WIDTH(32), .DEPTH(32), .TAG_W(4), .REQ_DEPTH(4), .RSP_DEPTH(4),
    .INIT_EN(1), .INIT_VALUE(IV)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus), .busy(busy)
  );

  logic [31:0] mem_arr [32];
  always @(posedge clock) if (bus.mem_we) mem_arr[bus.mem_waddr] <= bus.mem_wdata;
  assign bus.mem_rdata = mem_arr[bus.mem_raddr];

  typedef struct { logic [31:0] rdata; logic [3:0] tag; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] shadow [32];
  logic [3:0]  tag_ctr = 4'd0;

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  tag;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference model: shadow memory updated in acceptance order.
  task automatic mon();
    exp_t e;
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rsp_unexpected: got tag %0h with nothing outstanding", bus.rsp_tag);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
        chk("rsp_tag", 64'(bus.rsp_tag), 64'(e.tag));
      end
    end
    chk("one_issue", 64'(bus.mem_we & bus.mem_re), 64'd0);
    if (bus.req_valid && bus.req_ready) begin
      if (bus.req_write) shadow[bus.req_addr] = bus.req_wdata;
      else begin
        e.rdata = shadow[bus.req_addr];
        e.tag   = bus.req_tag;
        exp_q.push_back(e);
      end
      tag_ctr++;
    end
  endtask

  task automatic do_reset(input bit rr);
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = rr;
    #1;
    chk("rst_we", 64'(bus.mem_we), 64'd0);
    chk("rst_re", 64'(bus.mem_re), 64'd0);
    step();
    reset = 1'b0;
    bus.rsp_ready = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 32; i++) shadow[i] = IV;
  endtask

  task automatic init_check();
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("init_we", 64'(bus.mem_we), 64'd1);
      chk("init_waddr", 64'(bus.mem_waddr), 64'(i));
      chk("init_wdata", 64'(bus.mem_wdata), 64'(IV));
      chk("init_ready", 64'(bus.req_ready), 64'd0);
      chk("init_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("init_re", 64'(bus.mem_re), 64'd0);
      step();
    end
    #1;
    chk("run_ready", 64'(bus.req_ready), 64'd1);
    chk("run_we", 64'(bus.mem_we), 64'd0);
    chk("run_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("run_busy", 64'(busy), 64'd0);
    step();
  endtask

  task automatic send(input bit wr, input logic [4:0] a, input logic [31:0] d);
    int  n = 0;
    bit  done = 0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_tag   = tag_ctr;
    while (!done) begin
      #1;
      done = bus.req_ready;
      mon();
      step();
      n++;
      if (!done && n > 50) begin
        total++; bad++;
        $display("FAIL send_timeout: req_ready low for %0d cycles", n);
        done = 1;
      end
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 100; n++) begin
      #1;
      mon();
      if (!busy && exp_q.size() == 0) break;
      step();
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    chk("drain_busy", 64'(busy), 64'd0);
    step();
  endtask

  initial begin
    logic [3:0] t0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_tag   = '0;   bus.rsp_ready = 1'b0;

    // Power-on reset and init sweep.
    do_reset(1'b0);
    init_check();

    // Table: back-to-back mixed stream, exact issue and response timing.
    vecs[0] = '{1'b1, 5'd2, 32'h11,        4'd0, 32'h0};
    vecs[1] = '{1'b0, 5'd2, 32'h0,         4'd1, 32'h11};
    vecs[2] = '{1'b1, 5'd2, 32'h22,        4'd2, 32'h0};
    vecs[3] = '{1'b0, 5'd2, 32'h0,         4'd3, 32'h22};
    vecs[4] = '{1'b1, 5'd5, 32'hDEAD_BEEF, 4'd4, 32'h0};
    vecs[5] = '{1'b0, 5'd5, 32'h0,         4'd3, 32'hDEAD_BEEF};
    bus.rsp_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      if (t < 6) begin
        bus.req_valid = 1'b1;       bus.req_write = vecs[t].wr;
        bus.req_addr  = vecs[t].addr; bus.req_wdata = vecs[t].wdata;
        bus.req_tag   = vecs[t].tag;
      end else bus.req_valid = 1'b0;
      #1;
      mon();
      if (t < 6) chk("tbl_ready", 64'(bus.req_ready), 64'd1);
      if (t >= 1 && t <= 6) begin
        chk("tbl_we", 64'(bus.mem_we), 64'(vecs[t-1].wr));
        chk("tbl_re", 64'(bus.mem_re), 64'(!vecs[t-1].wr));
        if (vecs[t-1].wr) begin
          chk("tbl_waddr", 64'(bus.mem_waddr), 64'(vecs[t-1].addr));
          chk("tbl_wdata", 64'(bus.mem_wdata), 64'(vecs[t-1].wdata));
        end else chk("tbl_raddr", 64'(bus.mem_raddr), 64'(vecs[t-1].addr));
      end
      if (t >= 2) begin
        chk("tbl_rsp_valid", 64'(bus.rsp_valid), 64'(!vecs[t-2].wr));
        if (!vecs[t-2].wr) begin
          chk("tbl_rsp_rdata", 64'(bus.rsp_rdata), 64'(vecs[t-2].exp_rdata));
          chk("tbl_rsp_tag", 64'(bus.rsp_tag), 64'(vecs[t-2].tag));
        end
      end
      step();
    end

    // Backpressure: 4 responses queue, next read stalls, request FIFO fills.
    bus.rsp_ready = 1'b0;
    t0 = tag_ctr;
    for (int i = 0; i < 8; i++) send(1'b0, 5'(10 + i), 32'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      mon();
      chk("stall_ready", 64'(bus.req_ready), 64'd0);
      chk("stall_re", 64'(bus.mem_re), 64'd0);
      chk("stall_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("stall_rsp_tag", 64'(bus.rsp_tag), 64'(t0));
      chk("stall_busy", 64'(busy), 64'd1);
      step();
    end
    bus.rsp_ready = 1'b1;
    #1;
    mon();
    chk("full_popissue_re", 64'(bus.mem_re), 64'd1);
    chk("full_popissue_raddr", 64'(bus.mem_raddr), 64'd14);
    step();
    drain();

    // Reset while both FIFOs hold entries; rsp_ready high in the reset cycle.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(1'b0, 5'(20 + i), 32'h0);
    #1;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    chk("pre_rst_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    step();
    do_reset(1'b1);
    init_check();

    // Randomized traffic against the shadow-memory model.
    for (int c = 0; c < 400; c++) begin
      bus.req_valid = ($urandom_range(9) < 7);
      bus.req_write = 1'($urandom_range(1));
      bus.req_addr  = 5'($urandom_range(7));
      bus.req_wdata = $urandom;
      bus.req_tag   = tag_ctr;
      bus.rsp_ready = ($urandom_range(9) < 6);
      #1;
      mon();
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
